tone_write_sequencer: RTL



---
 rtl/tonegen_pkg.sv | 37 +++
 rtl/seq_pattern_mem.sv | 43 ++++
 rtl/tone_write_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/tonegen_pkg.sv
// Shared definitions for the tone generator write path: generator register map,
// bus widths, the (addr, data) write record and the sequencer state encoding.
package tonegen_pkg;

    localparam int GEN_ADDR_W = 3;
    localparam int GEN_DATA_W = 5;

    localparam logic [GEN_ADDR_W-1:0] GA_FREQ_LO = 3'd0;
    localparam logic [GEN_ADDR_W-1:0] GA_FREQ_HI = 3'd1;
    localparam logic [GEN_ADDR_W-1:0] GA_VOLUME  = 3'd2;
    localparam logic [GEN_ADDR_W-1:0] GA_WAVE    = 3'd3;
    localparam logic [GEN_ADDR_W-1:0] GA_DUTY    = 3'd4;
    localparam logic [GEN_ADDR_W-1:0] GA_ENV     = 3'd5;
    localparam logic [GEN_ADDR_W-1:0] GA_MIX     = 3'd6;
    localparam logic [GEN_ADDR_W-1:0] GA_CTRL    = 3'd7;

    // A pattern entry is {gen_write_t, dur}; dur is kept beside it because its width is a module parameter.
    typedef struct packed {
        logic [GEN_ADDR_W-1:0] addr;
        logic [GEN_DATA_W-1:0] data;
    } gen_write_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_e;

    function automatic gen_write_t make_write(input logic [GEN_ADDR_W-1:0] addr,
                                              input logic [GEN_DATA_W-1:0] data);
        gen_write_t w;
        w.addr = addr;
        w.data = data;
        return w;
    endfunction

endpackage

// File: rtl/seq_pattern_mem.sv
// Step pattern storage: synchronous write, combinational read (old data on a
// same-cycle read/write), a dedicated port for entry 0, and synchronous clear.
module seq_pattern_mem
    import tonegen_pkg::*;
#(
    parameter int STEPS = 8,
    parameter int DUR_W = 4,
    localparam int IDX_W = $clog2(STEPS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  gen_write_t       wr_write_i,
    input  logic [DUR_W-1:0] wr_dur_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output gen_write_t       rd_write_o,
    output logic [DUR_W-1:0] rd_dur_o,
    output gen_write_t       head_write_o,
    output logic [DUR_W-1:0] head_dur_o
);

    gen_write_t       write_q [STEPS];
    logic [DUR_W-1:0] dur_q   [STEPS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STEPS; i++) begin
                write_q[i] <= '0;
                dur_q[i]   <= '0;
            end
        end else if (we_i) begin
            write_q[wr_idx_i] <= wr_write_i;
            dur_q[wr_idx_i]   <= wr_dur_i;
        end
    end

    assign rd_write_o   = write_q[rd_idx_i];
    assign rd_dur_o     = dur_q[rd_idx_i];
    assign head_write_o = write_q[0];
    assign head_dur_o   = dur_q[0];

endmodule

// File: rtl/tone_write_sequencer.sv
// Plays a programmed (addr, data, duration) pattern and merges host pin writes onto
// the generator write bus, host first. SEQ_HOST_LOCK_EN drops host edges while busy.
module tone_write_sequencer
    import tonegen_pkg::*;
#(
    parameter int STEPS = 8,
    parameter int DUR_W = 4,
    localparam int IDX_W = $clog2(STEPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  host_strobe,
    input  logic [GEN_ADDR_W-1:0] host_addr,
    input  logic [GEN_DATA_W-1:0] host_data,
    input  logic                  prog_we,
    input  logic [IDX_W-1:0]      prog_idx,
    input  logic [GEN_ADDR_W-1:0] prog_addr,
    input  logic [GEN_DATA_W-1:0] prog_data,
    input  logic [DUR_W-1:0]      prog_dur,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop,
    output logic                  busy,
    output logic [IDX_W-1:0]      step_idx,
    output logic                  gen_strobe,
    output logic [GEN_ADDR_W-1:0] gen_addr,
    output logic [GEN_DATA_W-1:0] gen_data
);

    seq_state_e       state_q, state_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] step_idx_q, step_idx_d;
    logic             busy_q, busy_d;
    logic             gen_strobe_q, gen_strobe_d;
    gen_write_t       gen_wr_q, gen_wr_d;
    logic             host_prev_q;
    logic             seq_stb_q, seq_stb_d;

    logic             host_edge, host_go;
    logic             last_step, dur_done;
    logic [IDX_W-1:0] inc_idx, rd_idx;
    gen_write_t       rd_write, head_write;
    logic [DUR_W-1:0] rd_dur, head_dur;

    logic             seq_req, end_seq;
    logic [IDX_W-1:0] tgt_idx;
    gen_write_t       tgt_wr;
    logic [DUR_W-1:0] tgt_dur;

    seq_pattern_mem #(
        .STEPS (STEPS),
        .DUR_W (DUR_W)
    ) u_mem (
        .clk_i        (clk),
        .rst_i        (rst),
        .we_i         (prog_we),
        .wr_idx_i     (prog_idx),
        .wr_write_i   (make_write(prog_addr, prog_data)),
        .wr_dur_i     (prog_dur),
        .rd_idx_i     (rd_idx),
        .rd_write_o   (rd_write),
        .rd_dur_o     (rd_dur),
        .head_write_o (head_write),
        .head_dur_o   (head_dur)
    );

    assign host_edge = host_strobe & ~host_prev_q;
`ifdef SEQ_HOST_LOCK_EN
    assign host_go   = host_edge & ~busy_q;
`else
    assign host_go   = host_edge;
`endif

    assign last_step = (step_idx_q == IDX_W'(STEPS - 1));
    assign inc_idx   = step_idx_q + 1'b1;
    // A deferred issue re-reads its own entry; otherwise look ahead at the next one.
    assign rd_idx    = (state_q == ISSUE) ? step_idx_q : inc_idx;
    // The cycle in which the sequencer strobe is on the bus does not count ticks.
    assign dur_done  = (state_q == WAIT) & tick & ~seq_stb_q & (cnt_q == DUR_W'(1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        step_idx_d   = step_idx_q;
        gen_wr_d     = gen_wr_q;
        gen_strobe_d = 1'b0;
        seq_stb_d    = 1'b0;
        seq_req      = 1'b0;
        end_seq      = 1'b0;
        tgt_idx      = step_idx_q;
        tgt_wr       = rd_write;
        tgt_dur      = rd_dur;

        case (state_q)
            IDLE: begin
                if (start && head_dur != '0) begin
                    seq_req = 1'b1;
                    tgt_idx = '0;
                    tgt_wr  = head_write;
                    tgt_dur = head_dur;
                end
            end
            ISSUE: seq_req = 1'b1;
            WAIT: begin
                if (dur_done) begin
                    if (last_step && !loop) begin
                        end_seq = 1'b1;
                    end else if (rd_dur != '0) begin
                        seq_req = 1'b1;
                        tgt_idx = inc_idx;
                    end else if (loop && head_dur != '0) begin
                        seq_req = 1'b1;
                        tgt_idx = '0;
                        tgt_wr  = head_write;
                        tgt_dur = head_dur;
                    end else begin
                        end_seq = 1'b1;
                    end
                end else if (tick && !seq_stb_q) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (stop) begin
            state_d = IDLE;
        end else if (seq_req) begin
            step_idx_d = tgt_idx;
            if (host_go) begin
                state_d = ISSUE;
            end else begin
                state_d      = WAIT;
                cnt_d        = tgt_dur;
                seq_stb_d    = 1'b1;
                gen_strobe_d = 1'b1;
                gen_wr_d     = tgt_wr;
            end
        end else if (end_seq) begin
            state_d = IDLE;
        end

        if (host_go) begin
            gen_strobe_d = 1'b1;
            gen_wr_d     = make_write(host_addr, host_data);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            step_idx_q   <= '0;
            busy_q       <= 1'b0;
            gen_strobe_q <= 1'b0;
            gen_wr_q     <= '0;
            host_prev_q  <= 1'b0;
            seq_stb_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_idx_q   <= step_idx_d;
            busy_q       <= busy_d;
            gen_strobe_q <= gen_strobe_d;
            gen_wr_q     <= gen_wr_d;
            host_prev_q  <= host_strobe;
            seq_stb_q    <= seq_stb_d;
        end
    end

    assign busy       = busy_q;
    assign step_idx   = step_idx_q;
    assign gen_strobe = gen_strobe_q;
    assign gen_addr   = gen_wr_q.addr;
    assign gen_data   = gen_wr_q.data;

endmodule
